// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared state encoding and default timing for debounce_oneshot.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        ARM_HIGH = 2'd1,
        HIGH     = 2'd2,
        ARM_LOW  = 2'd3
    } db_state_e;

    localparam int TICK_CYCLES_DEF  = 100000;
    localparam int STABLE_TICKS_DEF = 10;

    // ARM_LOW still reports high: the level only drops once the low is qualified.
    function automatic logic state_is_high(input db_state_e s);
        return (s == HIGH) || (s == ARM_LOW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_oneshot_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Free-running divider giving a one-cycle tick every TICK_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
    import debounce_pkg::*;
#(
    parameter int TICK_CYCLES = TICK_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int             CW     = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0]  c_last = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] r_count;
    logic          w_tick;

    assign w_tick = (r_count == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = w_tick;

endmodule
`default_nettype wire

// File: rtl/debounce_oneshot.sv
`default_nettype none
// ============================================================================
// Module      : debounce_oneshot
// Description : Synchronize, tick-qualify and edge-detect one raw input.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_oneshot
    import debounce_pkg::*;
#(
    parameter int TICK_CYCLES  = TICK_CYCLES_DEF,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic db_level,
    output logic db_rise,
    output logic db_fall
);

    localparam int            SW            = $clog2(STABLE_TICKS + 1);
    localparam logic [SW-1:0] c_stable_last = SW'(STABLE_TICKS - 1);
    localparam logic [SW-1:0] c_stable_max  = SW'(STABLE_TICKS);

    logic          r_s1;
    logic          r_s_in;
    logic          w_tick;
    db_state_e     r_state;
    db_state_e     w_state_nxt;
    logic [SW-1:0] r_stable;
    logic [SW-1:0] w_stable_nxt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic          w_rise_nxt;
    logic          w_fall_nxt;

    // raw_in is asynchronous; only r_s1 may sample it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s_in <= 1'b0;
        end else begin
            r_s1   <= raw_in;
            r_s_in <= r_s1;
        end
    end

    tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= LOW;
            r_stable <= '0;
            r_level  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_stable <= w_stable_nxt;
            r_level  <= state_is_high(w_state_nxt);
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
        end
    end

    // A bounce back to the settled level wins over a tick in the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_stable_nxt = r_stable;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        case (r_state)
            LOW: begin
                if (r_s_in) begin
                    w_state_nxt  = ARM_HIGH;
                    w_stable_nxt = '0;
                end
            end
            ARM_HIGH: begin
                if (!r_s_in) begin
                    w_state_nxt = LOW;
                end else if (w_tick) begin
                    if (r_stable == c_stable_last) begin
                        w_state_nxt = HIGH;
                        w_rise_nxt  = 1'b1;
                    end else if (r_stable != c_stable_max) begin
                        w_stable_nxt = r_stable + 1'b1;
                    end
                end
            end
            HIGH: begin
                if (!r_s_in) begin
                    w_state_nxt  = ARM_LOW;
                    w_stable_nxt = '0;
                end
            end
            ARM_LOW: begin
                if (r_s_in) begin
                    w_state_nxt = HIGH;
                end else if (w_tick) begin
                    if (r_stable == c_stable_last) begin
                        w_state_nxt = LOW;
                        w_fall_nxt  = 1'b1;
                    end else if (r_stable != c_stable_max) begin
                        w_stable_nxt = r_stable + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = LOW;
            end
        endcase
    end

    assign db_level = r_level;
    assign db_rise  = r_rise;
    assign db_fall  = r_fall;

endmodule
`default_nettype wire

// File: tb/tb_debounce_oneshot.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_oneshot
// Description : Randomized self-checking bench against a cycle-level filter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_oneshot;

    localparam int TC = 4;
    localparam int ST = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic raw_in;
    logic db_level;
    logic db_rise;
    logic db_fall;

    always #5 clk = ~clk;

    debounce_oneshot #(
        .TICK_CYCLES  (TC),
        .STABLE_TICKS (ST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_in   (raw_in),
        .db_level (db_level),
        .db_rise  (db_rise),
        .db_fall  (db_fall)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: the level flips once the synchronized input has disagreed with it
    // for two cycles and then for ST consecutive ticks (tick every TC edges since reset).
    int m_k;
    int m_run;
    int m_ticks;
    bit m_s1, m_sin, m_lvl, m_rise, m_fall;

    task automatic model_reset();
        m_k = 0; m_run = 0; m_ticks = 0;
        m_s1 = 0; m_sin = 0; m_lvl = 0; m_rise = 0; m_fall = 0;
    endtask

    task automatic model_edge(input bit raw);
        bit tick;
        bit flip;
        tick   = ((m_k % TC) == TC - 1);
        flip   = 0;
        m_rise = 0;
        m_fall = 0;
        if (m_sin == m_lvl) begin
            m_ticks = 0;
        end else if (m_run >= 2 && tick) begin
            m_ticks++;
            if (m_ticks == ST) begin
                flip    = 1;
                m_ticks = 0;
            end
        end
        if (flip) begin
            m_lvl  = !m_lvl;
            m_rise = m_lvl;
            m_fall = !m_lvl;
        end
        m_sin = m_s1;
        m_s1  = raw;
        m_k++;
        if (m_sin != m_lvl) m_run = flip ? 1 : ((m_run < 2) ? m_run + 1 : 2);
        else                m_run = 0;
    endtask

    task automatic cycle(input bit raw);
        raw_in = raw;
        @(posedge clk);
        model_edge(raw);
        #1;
        check_val("db_level", db_level, m_lvl);
        check_val("db_rise",  db_rise,  m_rise);
        check_val("db_fall",  db_fall,  m_fall);
        check_val("rise_fall_exclusive", db_rise & db_fall, 0);
        @(negedge clk);
    endtask

    task automatic run_window(input bit raw, input int n, output int n_r, output int n_f,
                              output int first_r, output int first_f);
        n_r = 0; n_f = 0; first_r = -1; first_f = -1;
        for (int i = 0; i < n; i++) begin
            cycle(raw);
            if (db_rise) begin n_r++; if (first_r < 0) first_r = i; end
            if (db_fall) begin n_f++; if (first_f < 0) first_f = i; end
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("rst_level", db_level, 0);
        check_val("rst_rise",  db_rise,  0);
        check_val("rst_fall",  db_fall,  0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_val("rst_hold_outputs", {db_level, db_rise, db_fall}, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int nr, nf, fr, ff, tot_r, tot_f, len, left;
    bit lvl;

    initial begin
        raw_in = 1'b1;
        rst_n  = 1'b0;
        @(negedge clk);

        // 1: reset with raw high; qualification starts fresh after release
        do_reset(3);
        run_window(1, 20, nr, nf, fr, ff);
        check_val($sformatf("t1_rise_edge_in_11_14(e=%0d)", fr), (fr >= 11 && fr <= 14), 1);
        check_val("t1_rise_count", nr, 1);

        // 2: clean press
        run_window(0, 20, nr, nf, fr, ff);
        run_window(1, 15, nr, nf, fr, ff);
        check_val($sformatf("t2_rise_edge_in_11_14(e=%0d)", fr), (fr >= 11 && fr <= 14), 1);
        check_val("t2_rise_count", nr, 1);
        run_window(1, 100, nr, nf, fr, ff);
        check_val("t2_sustained_rises", nr, 0);
        check_val("t2_sustained_level", db_level, 1);

        // 3: bounce rejection
        run_window(0, 20, nr, nf, fr, ff);
        tot_r = 0;
        run_window(1, 6, nr, nf, fr, ff);  tot_r += nr;
        run_window(0, 2, nr, nf, fr, ff);  tot_r += nr;
        run_window(1, 6, nr, nf, fr, ff);  tot_r += nr;
        run_window(0, 20, nr, nf, fr, ff); tot_r += nr;
        check_val("t3_bounce_rises", tot_r, 0);
        check_val("t3_level", db_level, 0);
        check_val("t3_state_low", dut.r_state, 0);

        // 4: clean release
        run_window(1, 20, nr, nf, fr, ff);
        run_window(0, 20, nr, nf, fr, ff);
        check_val($sformatf("t4_fall_edge_in_11_14(e=%0d)", ff), (ff >= 11 && ff <= 14), 1);
        check_val("t4_fall_count", nf, 1);
        check_val("t4_rise_count", nr, 0);
        check_val("t4_level", db_level, 0);

        // 5: reset in the middle of qualification
        run_window(1, 8, nr, nf, fr, ff);
        check_val("t5_pre_reset_pulses", nr + nf, 0);
        do_reset(3);
        run_window(1, 20, nr, nf, fr, ff);
        check_val($sformatf("t5_rise_edge_in_11_14(e=%0d)", fr), (fr >= 11 && fr <= 14), 1);
        check_val("t5_rise_count", nr, 1);

        // 6: random short runs, then a long stable high
        run_window(0, 20, nr, nf, fr, ff);
        tot_r = 0; tot_f = 0; left = 200; lvl = 1;
        while (left > 0) begin
            len = $urandom_range(1, 7);
            if (len > left) len = left;
            run_window(lvl, len, nr, nf, fr, ff);
            tot_r += nr; tot_f += nf;
            left -= len;
            lvl = !lvl;
        end
        check_val("t6_random_pulses", tot_r + tot_f, 0);
        run_window(1, 20, nr, nf, fr, ff);
        check_val("t6_final_rise_count", nr, 1);
        check_val("t6_final_level", db_level, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debounce_oneshot.md
Name: debounce_oneshot

Overview:
- Conditions one raw asynchronous input, such as a push-button or an external event line, into clean single-cycle event pulses.
- Its db_rise output feeds the set input of the interrupt/request latch downstream. That latch holds the event until the consumer clears it.
- Stages: 2-flop synchronizer, tick-based stability filter, edge one-shot.
- One instance per raw input.

Parameters:
- TICK_CYCLES, 100000: clock cycles per sample tick (1 ms at 100 MHz); legal range ≥ 2.
- STABLE_TICKS, 10: consecutive ticks the synchronized input must stay constant before the debounced level changes; legal range ≥ 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- raw_in  in  1  raw input; asynchronous to clk and may bounce.
- db_level  out  1  debounced level, registered.
- db_rise  out  1  one-cycle pulse on each debounced 0→1 transition, registered.
- db_fall  out  1  one-cycle pulse on each debounced 1→0 transition, registered.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sync flops, tick counter and stable counter clear to 0; state goes to LOW.
  - db_level=0, db_rise=0, db_fall=0.
  - Leaving reset never produces a pulse, whatever the level of raw_in.
- Synchronizer: raw_in → s1 → s_in, two flops. No other logic reads raw_in.
- Tick counter:
  - Free-runs 0..TICK_CYCLES-1 and wraps to 0.
  - tick is combinational, high when count==TICK_CYCLES-1.
  - Width is $clog2(TICK_CYCLES).
- Stable counter: width $clog2(STABLE_TICKS+1); it saturates and never wraps.
- FSM states: LOW, ARM_HIGH, HIGH, ARM_LOW.
  - LOW: s_in=1 → ARM_HIGH, stable count cleared.
  - ARM_HIGH:
    - s_in=0 → LOW, no pulse (bounce rejected).
    - Else on tick: if count==STABLE_TICKS-1 → HIGH; otherwise count+1.
  - HIGH: s_in=0 → ARM_LOW, stable count cleared.
  - ARM_LOW:
    - s_in=1 → HIGH, no pulse.
    - Else on tick: if count==STABLE_TICKS-1 → LOW; otherwise count+1.
  - The bounce check (s_in) takes priority over tick in the same cycle.
- Outputs:
  - db_level=1 exactly in states HIGH and ARM_LOW.
  - db_rise is high for exactly the one cycle after the edge entering HIGH from ARM_HIGH.
  - db_fall is high for exactly the one cycle after the edge entering LOW from ARM_LOW.
  - db_rise and db_fall are never high together.
  - db_rise and db_level rise on the same edge.
- Latency: from the first edge that captures a new raw_in value into s1 to the output edge:
  - +1 edge for s_in, +1 edge to enter the ARM state;
  - then the STABLE_TICKS-th tick, which falls between (STABLE_TICKS-1)·TICK_CYCLES+1 and STABLE_TICKS·TICK_CYCLES cycles later.
- Sustained level: an input held high or low indefinitely produces no further pulses.
- Reset mid-ARM: any pending qualification is discarded; a fresh full window is required after release.

Decomposition:
- Shared package (debounce_pkg):
  - state enum {LOW, ARM_HIGH, HIGH, ARM_LOW}, 2-bit encoding;
  - default constants TICK_CYCLES_DEF=100000 and STABLE_TICKS_DEF=10.
- One sub-module, tick_gen:
  - parameter TICK_CYCLES; ports clk, rst_n, tick;
  - reusable by other timed blocks in the design.

Test Plan:
All scenarios use TICK_CYCLES=4 and STABLE_TICKS=3; E0 is the first edge that samples the new raw_in into s1.
1. Reset state: rst_n=0 with raw_in=1, then release → all outputs 0 during reset, and no db_rise before 11 edges after release.
2. Clean press: raw_in 0→1 and held → db_level 0→1 with a one-cycle db_rise at an edge within E11..E14; db_rise low on every other cycle for 100 further cycles.
3. Bounce rejection: raw_in high 6 cycles, low 2, high 6, then low → no db_rise, db_level stays 0, state returns to LOW.
4. Clean release: from HIGH, raw_in 1→0 and held → one-cycle db_fall within E11..E14 and db_level 0; db_rise never asserts.
5. Reset mid-operation: raw_in high, rst_n pulsed low at E8 for 3 cycles → no pulse; after release, db_rise only after a fresh 11..14-edge window.
6. Stress: 200 cycles of random raw_in with run lengths ≤ 7 → zero pulses; then 20 cycles stable high → exactly one db_rise.
